// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: opcodes, the state
// enum, datapath mux selects, immediate formats and halt cause codes.
package mc_ctrl_pkg;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL, S_JALR, S_LUI, S_AUIPC,
    S_HALT
  } state_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'b11;

  // States that hold a memory request open until mem_ready.
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the IR/memory side and the multi-cycle datapath.
// ctrl is the FSM's view, dp is the datapath/memory view.
interface mc_control_fsm_if #(parameter int IMM_W = 3);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             mem_ready;
  logic             mem_req;
  logic             MemWrite;
  logic             IRWrite;
  logic             PCUpdate;
  logic             Branch;
  logic             AdrSrc;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [IMM_W-1:0] ImmSrc;
  logic             instr_retire;
  logic             halted;
  logic [1:0]       halt_cause;

  modport ctrl (
    input  op, funct3, mem_ready,
    output mem_req, MemWrite, IRWrite, PCUpdate, Branch, AdrSrc, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_retire,
           halted, halt_cause
  );

  modport dp (
    output op, funct3, mem_ready,
    input  mem_req, MemWrite, IRWrite, PCUpdate, Branch, AdrSrc, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_retire,
           halted, halt_cause
  );
endinterface

// File: rtl/mc_imm_decode.sv
// Combinational opcode to immediate-format map; unknown opcodes give I-type.
module mc_imm_decode
  import mc_ctrl_pkg::*;
#(
  parameter int IMM_W = 3
) (
  input  logic [6:0]       op,
  output logic [IMM_W-1:0] imm_src
);

  // Immediate format is purely a function of the opcode.
  always_comb begin
    imm_src = IMM_W'(IMM_I);
    case (op)
      OP_SW:            imm_src = IMM_W'(IMM_S);
      OP_BRANCH:        imm_src = IMM_W'(IMM_B);
      OP_JAL:           imm_src = IMM_W'(IMM_J);
      OP_LUI, OP_AUIPC: imm_src = IMM_W'(IMM_U);
      default:          imm_src = IMM_W'(IMM_I);
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM with memory wait handshake, bus timeout,
// illegal-instruction detection and a sticky HALT carrying a cause code.
// Optional build macro: MC_FSM_SYSTEM_EN makes ECALL/EBREAK retire and halt
// with the system cause; without it that opcode is treated as illegal.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 5,
  parameter int IMM_W        = 3
) (
  input logic          clk,
  input logic          rst,
  mc_control_fsm_if.ctrl bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT > 0 ? WAIT_TIMEOUT - 1 : 0);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [1:0]       cause_reg, cause_next;
  logic             timeout;

  // The access expires on the cycle that would push the wait count to the limit.
  generate
    if (WAIT_TIMEOUT != 0) begin : g_tmo
      assign timeout = !bus.mem_ready && (wait_cnt_reg == CNT_LAST);
    end else begin : g_no_tmo
      assign timeout = 1'b0;
    end
  endgenerate

  mc_imm_decode #(.IMM_W(IMM_W)) u_imm (.op(bus.op), .imm_src(bus.ImmSrc));

  assign bus.halt_cause = cause_reg;

  // State, wait counter and halt cause registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
      cause_reg    <= CAUSE_NONE;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      cause_reg    <= cause_next;
    end
  end

  // Next-state and Moore outputs; mem_ready qualifies only the memory states.
  always_comb begin
    state_next       = state_reg;
    cause_next       = cause_reg;
    bus.mem_req      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.PCUpdate     = 1'b0;
    bus.Branch       = 1'b0;
    bus.AdrSrc       = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.ResultSrc    = RES_ALUOUT;
    bus.ALUSrcA      = SRCA_PC;
    bus.ALUSrcB      = SRCB_RS2;
    bus.ALUOp        = ALU_ADD;
    bus.instr_retire = 1'b0;
    bus.halted       = 1'b0;

    case (state_reg)
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        if (bus.mem_ready) begin
          bus.IRWrite  = 1'b1;
          bus.PCUpdate = 1'b1;
          state_next   = S_DECODE;
        end else if (timeout) begin
          state_next = S_HALT;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        state_next  = S_HALT;
        cause_next  = CAUSE_ILLEGAL;
        case (bus.op)
          OP_LW, OP_SW: if (bus.funct3 == 3'b010) begin
            state_next = S_MEMADR; cause_next = cause_reg;
          end
          OP_JALR:   begin state_next = S_MEMADR; cause_next = cause_reg; end
          OP_R:      begin state_next = S_EXEC_R; cause_next = cause_reg; end
          OP_I:      begin state_next = S_EXEC_I; cause_next = cause_reg; end
          OP_JAL:    begin state_next = S_JAL;    cause_next = cause_reg; end
          OP_LUI:    begin state_next = S_LUI;    cause_next = cause_reg; end
          OP_AUIPC:  begin state_next = S_AUIPC;  cause_next = cause_reg; end
          OP_BRANCH: if (bus.funct3 != 3'b010 && bus.funct3 != 3'b011) begin
            state_next = S_BEQ; cause_next = cause_reg;
          end
`ifdef MC_FSM_SYSTEM_EN
          OP_SYSTEM: begin bus.instr_retire = 1'b1; cause_next = CAUSE_SYSTEM; end
`endif
          default: ;
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        if (bus.op == OP_JALR) state_next = S_JALR;
        else if (bus.op[5])    state_next = S_MEMWRITE;
        else                   state_next = S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.AdrSrc  = 1'b1;
        if (bus.mem_ready) state_next = S_MEMWB;
        else if (timeout) begin state_next = S_HALT; cause_next = CAUSE_TIMEOUT; end
      end
      S_MEMWB: begin
        bus.ResultSrc    = RES_DATA;
        bus.RegWrite     = 1'b1;
        bus.instr_retire = 1'b1;
        state_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.mem_req  = 1'b1;
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_retire = 1'b1;
          state_next       = S_FETCH;
        end else if (timeout) begin
          state_next = S_HALT; cause_next = CAUSE_TIMEOUT;
        end
      end
      S_EXEC_R: begin
        bus.ALUSrcA = SRCA_RS1; bus.ALUSrcB = SRCB_RS2; bus.ALUOp = ALU_FUNCT;
        state_next  = S_ALUWB;
      end
      S_EXEC_I: begin
        bus.ALUSrcA = SRCA_RS1; bus.ALUSrcB = SRCB_IMM; bus.ALUOp = ALU_FUNCT;
        state_next  = S_ALUWB;
      end
      S_LUI: begin
        bus.ALUSrcA = SRCA_ZERO; bus.ALUSrcB = SRCB_IMM;
        state_next  = S_ALUWB;
      end
      S_AUIPC: begin
        bus.ALUSrcA = SRCA_OLDPC; bus.ALUSrcB = SRCB_IMM;
        state_next  = S_ALUWB;
      end
      S_JAL, S_JALR: begin
        // Link value PC+4 goes to ALUResult while ALUOut (target) loads the PC.
        bus.ALUSrcA  = SRCA_OLDPC; bus.ALUSrcB = SRCB_FOUR;
        bus.PCUpdate = 1'b1;
        state_next   = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite     = 1'b1;
        bus.instr_retire = 1'b1;
        state_next       = S_FETCH;
      end
      S_BEQ: begin
        bus.ALUSrcA = SRCA_RS1; bus.ALUSrcB = SRCB_RS2; bus.ALUOp = ALU_SUB;
        bus.Branch       = 1'b1;
        bus.instr_retire = 1'b1;
        state_next       = S_FETCH;
      end
      S_HALT: bus.halted = 1'b1;
      default: begin
        state_next = S_HALT;
        cause_next = CAUSE_ILLEGAL;
      end
    endcase

    // While in reset present a quiet FETCH: selects as FETCH, nothing enabled.
    if (rst) begin
      bus.mem_req      = 1'b0;
      bus.MemWrite     = 1'b0;
      bus.IRWrite      = 1'b0;
      bus.PCUpdate     = 1'b0;
      bus.Branch       = 1'b0;
      bus.RegWrite     = 1'b0;
      bus.AdrSrc       = 1'b0;
      bus.ResultSrc    = RES_ALURESULT;
      bus.ALUSrcA      = SRCA_PC;
      bus.ALUSrcB      = SRCB_FOUR;
      bus.ALUOp        = ALU_ADD;
      bus.instr_retire = 1'b0;
      bus.halted       = 1'b0;
    end
  end

  // Wait count restarts on every state change and counts stalled cycles.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (state_next != state_reg)
      wait_cnt_next = '0;
    else if (is_wait_state(state_reg) && !bus.mem_ready)
      wait_cnt_next = wait_cnt_reg + CNT_W'(1);
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: each instruction is expanded into the expected
// per-cycle step list (with chosen memory wait counts), driven and compared.
// Honours MC_FSM_SYSTEM_EN for the ECALL expectation.
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_control_fsm_if #(.IMM_W(3)) bus ();
  mc_control_fsm #(.WAIT_TIMEOUT(TMO), .CNT_W(3), .IMM_W(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic mem_req, mem_write, ir_write, pc_update, branch, adr_src, reg_write;
    logic [1:0] result_src, src_a, src_b, alu_op;
    logic retire, halted;
  } ctl_t;

  typedef enum {K_FW, K_FG, K_DEC, K_DSYS, K_MA, K_RW, K_RG, K_MWB, K_WW, K_WG,
                K_EXR, K_EXI, K_LUI, K_AUI, K_JMP, K_AWB, K_BEQ, K_HALT} kind_t;
  typedef struct {logic rdy; kind_t kind; logic [1:0] cause;} step_t;
  typedef struct {logic [6:0] op; logic [2:0] imm;} imm_vec_t;

  step_t q[$];
  int passed = 0;
  int total  = 0;
  logic [6:0] ops [12] = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_JALR, OP_BRANCH,
                          OP_LUI, OP_AUIPC, OP_SYSTEM, 7'h00, 7'h7f};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Required datapath controls for each kind of step.
  function automatic ctl_t ctl_of(kind_t k);
    ctl_t c = '0;
    case (k)
      K_FW, K_FG: begin
        c.mem_req = 1; c.src_b = 2; c.result_src = 2;
        c.ir_write = (k == K_FG); c.pc_update = (k == K_FG);
      end
      K_DEC, K_DSYS: begin c.src_a = 1; c.src_b = 1; c.retire = (k == K_DSYS); end
      K_MA:   begin c.src_a = 2; c.src_b = 1; end
      K_RW, K_RG: begin c.mem_req = 1; c.adr_src = 1; end
      K_MWB:  begin c.result_src = 1; c.reg_write = 1; c.retire = 1; end
      K_WW, K_WG: begin
        c.mem_req = 1; c.adr_src = 1; c.mem_write = 1; c.retire = (k == K_WG);
      end
      K_EXR:  begin c.src_a = 2; c.src_b = 0; c.alu_op = 2; end
      K_EXI:  begin c.src_a = 2; c.src_b = 1; c.alu_op = 2; end
      K_LUI:  begin c.src_a = 3; c.src_b = 1; end
      K_AUI:  begin c.src_a = 1; c.src_b = 1; end
      K_JMP:  begin c.src_a = 1; c.src_b = 2; c.pc_update = 1; end
      K_AWB:  begin c.reg_write = 1; c.retire = 1; end
      K_BEQ:  begin c.src_a = 2; c.alu_op = 1; c.branch = 1; c.retire = 1; end
      K_HALT: c.halted = 1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctl_t ctl_now();
    ctl_t c;
    c.mem_req = bus.mem_req;     c.mem_write = bus.MemWrite; c.ir_write = bus.IRWrite;
    c.pc_update = bus.PCUpdate;  c.branch = bus.Branch;      c.adr_src = bus.AdrSrc;
    c.reg_write = bus.RegWrite;  c.result_src = bus.ResultSrc;
    c.src_a = bus.ALUSrcA;       c.src_b = bus.ALUSrcB;      c.alu_op = bus.ALUOp;
    c.retire = bus.instr_retire; c.halted = bus.halted;
    return c;
  endfunction

  function automatic void push(logic r, kind_t k, logic [1:0] c);
    q.push_back('{r, k, c});
  endfunction

  function automatic void push_halt(logic [1:0] c);
    for (int i = 0; i < 3; i++) push(1'($urandom_range(0, 1)), K_HALT, c);
  endfunction

  // A memory access stalled for 'waits' cycles; returns 0 if it times out.
  function automatic bit access(int waits, kind_t kw, kind_t kg);
    for (int i = 0; i < waits && i < TMO; i++) push(1'b0, kw, 2'b00);
    if (waits >= TMO) begin
      push_halt(CAUSE_TIMEOUT);
      return 1'b0;
    end
    push(1'b1, kg, 2'b00);
    return 1'b1;
  endfunction

  // Expected step list for one instruction from fetch to retire or halt.
  task automatic plan(logic [6:0] o, logic [2:0] f, int wf, int wm);
    q.delete();
    bus.op = o;
    bus.funct3 = f;
    if (!access(wf, K_FW, K_FG)) return;
    case (o)
      OP_LW: if (f == 3'b010) begin
        push(1'b0, K_DEC, 0); push(1'b0, K_MA, 0);
        if (access(wm, K_RW, K_RG)) push(1'b0, K_MWB, 0);
      end else begin push(1'b0, K_DEC, 0); push_halt(CAUSE_ILLEGAL); end
      OP_SW: if (f == 3'b010) begin
        push(1'b0, K_DEC, 0); push(1'b0, K_MA, 0);
        void'(access(wm, K_WW, K_WG));
      end else begin push(1'b0, K_DEC, 0); push_halt(CAUSE_ILLEGAL); end
      OP_R:     begin push(1'b1, K_DEC, 0); push(1'b0, K_EXR, 0); push(1'b1, K_AWB, 0); end
      OP_I:     begin push(1'b0, K_DEC, 0); push(1'b1, K_EXI, 0); push(1'b0, K_AWB, 0); end
      OP_JAL:   begin push(1'b0, K_DEC, 0); push(1'b0, K_JMP, 0); push(1'b1, K_AWB, 0); end
      OP_JALR:  begin
        push(1'b0, K_DEC, 0); push(1'b1, K_MA, 0); push(1'b0, K_JMP, 0); push(1'b0, K_AWB, 0);
      end
      OP_LUI:   begin push(1'b0, K_DEC, 0); push(1'b0, K_LUI, 0); push(1'b0, K_AWB, 0); end
      OP_AUIPC: begin push(1'b1, K_DEC, 0); push(1'b0, K_AUI, 0); push(1'b1, K_AWB, 0); end
      OP_BRANCH: begin
        push(1'b0, K_DEC, 0);
        if (f == 3'b010 || f == 3'b011) push_halt(CAUSE_ILLEGAL);
        else push(1'b0, K_BEQ, 0);
      end
`ifdef MC_FSM_SYSTEM_EN
      OP_SYSTEM: begin push(1'b0, K_DSYS, 0); push_halt(CAUSE_SYSTEM); end
`endif
      default: begin push(1'b0, K_DEC, 0); push_halt(CAUSE_ILLEGAL); end
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    #2;
    chk("rst enables", {bus.IRWrite, bus.PCUpdate, bus.RegWrite, bus.MemWrite, bus.instr_retire}, 0);
    chk("rst halted", bus.halted, 0);
    chk("rst selects", {bus.ALUSrcB, bus.ResultSrc, bus.ALUSrcA}, 6'b101000);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post-rst fetch", {bus.mem_req, bus.IRWrite, bus.halted}, 3'b100);
    chk("post-rst cause", bus.halt_cause, CAUSE_NONE);
  endtask

  // Drive the planned steps, compare every cycle, and report observed events.
  task automatic run_plan(string tag, output int ret_at, output int irw, output int mw);
    ret_at = 0; irw = 0; mw = 0;
    for (int i = 0; i < q.size(); i++) begin
      bus.mem_ready = q[i].rdy;
      #2;
      chk($sformatf("%s step%0d ctl", tag, i), ctl_now(), ctl_of(q[i].kind));
      if (q[i].kind == K_HALT)
        chk($sformatf("%s step%0d cause", tag, i), bus.halt_cause, q[i].cause);
      if (bus.instr_retire && ret_at == 0) ret_at = i + 1;
      irw += int'(bus.IRWrite);
      mw  += int'(bus.MemWrite);
      @(posedge clk); #1;
    end
    $display("txn %s op=%b f3=%b cycles=%0d retire_at=%0d", tag, bus.op, bus.funct3, q.size(), ret_at);
    if (q[q.size()-1].kind == K_HALT) do_reset();
  endtask

  initial begin
    imm_vec_t iv[10];
    int r, iw, mw;
    logic [6:0] o;
    logic [2:0] f;

    bus.op = 7'h00; bus.funct3 = 3'b000; bus.mem_ready = 1'b0;
    iv[0] = '{OP_LW, IMM_I};     iv[1] = '{OP_SW, IMM_S};    iv[2] = '{OP_BRANCH, IMM_B};
    iv[3] = '{OP_JAL, IMM_J};    iv[4] = '{OP_LUI, IMM_U};   iv[5] = '{OP_AUIPC, IMM_U};
    iv[6] = '{OP_JALR, IMM_I};   iv[7] = '{OP_I, IMM_I};     iv[8] = '{OP_R, IMM_I};
    iv[9] = '{7'h7f, IMM_I};

    do_reset();

    foreach (iv[i]) begin
      bus.op = iv[i].op;
      #1;
      chk($sformatf("imm op=%b", iv[i].op), bus.ImmSrc, iv[i].imm);
    end

    plan(OP_R, 3'b000, 0, 0);       run_plan("add", r, iw, mw);
    chk("add retire cycle", r, 4);
    chk("add irwrite count", iw, 1);

    plan(OP_LW, 3'b010, 3, 3);      run_plan("lw", r, iw, mw);
    chk("lw retire cycle", r, 11);
    chk("lw irwrite count", iw, 1);

    plan(OP_SW, 3'b010, 0, 9);      run_plan("sw_timeout", r, iw, mw);
    chk("sw memwrite cycles", mw, 4);

    plan(7'h00, 3'b000, 0, 0);      run_plan("op0", r, iw, mw);
    plan(OP_JALR, 3'b000, 0, 0);    run_plan("jalr", r, iw, mw);
    plan(OP_LUI, 3'b000, 0, 0);     run_plan("lui", r, iw, mw);
    chk("lui immsrc", bus.ImmSrc, IMM_U);
    plan(OP_BRANCH, 3'b011, 0, 0);  run_plan("beq_f3_3", r, iw, mw);
    plan(OP_SYSTEM, 3'b000, 0, 0);  run_plan("ecall", r, iw, mw);

    // Reset in the middle of a stalled store.
    bus.op = OP_SW; bus.funct3 = 3'b010;
    bus.mem_ready = 1'b1; @(posedge clk); #1;
    bus.mem_ready = 1'b0; @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sw stalled memwrite", {bus.mem_req, bus.MemWrite}, 2'b11);
    rst = 1'b1; #1;
    chk("rst drops memwrite", bus.MemWrite, 0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("after rst fetch", {bus.MemWrite, bus.mem_req, bus.AdrSrc}, 3'b010);

    for (int n = 0; n < 250; n++) begin
      o = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
      f = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b010;
      if (o == OP_BRANCH && $urandom_range(0, 1) == 0) f = 3'b000;
      plan(o, f,
           ($urandom_range(0, 9) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3),
           ($urandom_range(0, 9) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3));
      run_plan($sformatf("rnd%0d", n), r, iw, mw);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
